// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the accumulator sequencer: opcodes, peer-ALU control codes
// and the sequencer state encoding.
package alu_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_ORN  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_ANDN = 3'b101;
  localparam logic [2:0] ALU_NOT0 = 3'b110;
  localparam logic [2:0] ALU_NOT1 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_MUL_ITER = 2'd2,
    ST_WB       = 2'd3
  } seq_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_sequencer_zero_detect.sv
// N-bit NOR used for the Z flag; the sequencer never trusts the ALU for zero.
module alu_sequencer_zero_detect #(
  parameter int N = 4
) (
  input  logic [N-1:0] value,
  output logic         is_zero
);

  assign is_zero = ~|value;

endmodule

// File: rtl/alu_sequencer.sv
// Accumulator instruction sequencer driving an external N-bit ALU as a peer.
// Single ops go IDLE->EXEC->WB; MUL does N shift-and-add passes through the ALU.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         instr_valid,
  input  logic [3:0]   instr_op,
  input  logic [N-1:0] instr_operand,
  output logic         instr_ready,
  output logic [N-1:0] alu_in0,
  output logic [N-1:0] alu_in1,
  output logic         alu_c_in,
  output logic [2:0]   alu_ctrl,
  input  logic [N-1:0] alu_out,
  input  logic         alu_c_out,
  input  logic         alu_v,
  output logic [N-1:0] acc,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         done,
  output logic         err
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  seq_state_t state_q, state_d;

  logic [3:0]       op_q;
  logic [N-1:0]     operand_q;
  logic [N-1:0]     multiplier_q;
  logic [N-1:0]     prod_q;
  logic [N-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_c_q, flag_v_q, flag_z_q, err_q;

  logic             accept;
  logic             mul_last;
  logic [N-1:0]     mul_next;
  logic [N-1:0]     zero_src;
  logic             zero_hit;

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign mul_last    = (cnt_q == CNT_LAST);
  assign mul_next    = multiplier_q[cnt_q] ? alu_out : prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = (instr_op == OP_MUL) ? ST_MUL_ITER : ST_EXEC;
      ST_EXEC:     state_d = ST_WB;
      ST_MUL_ITER: if (mul_last) state_d = ST_WB;
      ST_WB:       state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Idle ALU drive is acc+0 so the peer ALU sees stable, harmless operands.
  always_comb begin
    alu_in0  = acc_q;
    alu_in1  = '0;
    alu_ctrl = ALU_ADD;
    alu_c_in = 1'b0;
    case (state_q)
      ST_EXEC: begin
        alu_in1 = operand_q;
        case (op_q)
          OP_ADC: alu_c_in = flag_c_q;
          OP_SUB, OP_CMP: begin
            alu_ctrl = ALU_SUB;
            alu_c_in = 1'b1;
          end
          OP_OR:   alu_ctrl = ALU_OR;
          OP_AND:  alu_ctrl = ALU_AND;
          OP_NOT:  alu_ctrl = ALU_NOT0;
          default: ;
        endcase
      end
      ST_MUL_ITER: begin
        alu_in0 = prod_q;
        alu_in1 = operand_q << cnt_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    zero_src = alu_out;
    if (state_q == ST_MUL_ITER)  zero_src = mul_next;
    else if (op_q == OP_LDA)     zero_src = operand_q;
  end

  alu_sequencer_zero_detect #(.N(N)) u_zero_detect (
    .value   (zero_src),
    .is_zero (zero_hit)
  );

  // The multiplier is snapshotted from acc at accept so acc can take the product directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_NOP;
      operand_q    <= '0;
      multiplier_q <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      flag_c_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q         <= instr_op;
            operand_q    <= instr_operand;
            multiplier_q <= acc_q;
            prod_q       <= '0;
            cnt_q        <= '0;
          end
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD, OP_ADC, OP_SUB: begin
              acc_q    <= alu_out;
              flag_c_q <= alu_c_out;
              flag_v_q <= alu_v;
              flag_z_q <= zero_hit;
            end
            OP_CMP: begin
              flag_c_q <= alu_c_out;
              flag_v_q <= alu_v;
              flag_z_q <= zero_hit;
            end
            OP_OR, OP_AND, OP_NOT: begin
              acc_q    <= alu_out;
              flag_z_q <= zero_hit;
            end
            OP_LDA: begin
              acc_q    <= operand_q;
              flag_z_q <= zero_hit;
            end
            default: begin
              if (!op_is_legal(op_q)) err_q <= 1'b1;
            end
          endcase
        end
        ST_MUL_ITER: begin
          prod_q <= mul_next;
          if (mul_last) begin
            cnt_q    <= '0;
            acc_q    <= mul_next;
            flag_z_q <= zero_hit;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign acc    = acc_q;
  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
  assign flag_z = flag_z_q;
  assign err    = err_q;
  assign done   = (state_q == ST_WB);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural peer ALU and an
// arithmetic reference model of the accumulator, flags and error bit.
module tb_alu_sequencer;

  localparam int N    = 4;
  localparam int MOD  = 1 << N;
  localparam int HALF = 1 << (N - 1);

  localparam logic [3:0] OP_NOP = 4'd0, OP_LDA = 4'd1, OP_ADD = 4'd2, OP_ADC = 4'd3;
  localparam logic [3:0] OP_OR = 4'd5, OP_AND = 4'd6, OP_NOT = 4'd7, OP_CMP = 4'd8, OP_MUL = 4'd9;

  logic         clk, rst_n;
  logic         instr_valid, instr_ready;
  logic [3:0]   instr_op;
  logic [N-1:0] instr_operand;
  logic [N-1:0] alu_in0, alu_in1, alu_out;
  logic         alu_c_in, alu_c_out, alu_v;
  logic [2:0]   alu_ctrl;
  logic [N-1:0] acc;
  logic         flag_c, flag_v, flag_z, done, err;

  int checks = 0;
  int errors = 0;

  int   m_acc;
  logic m_c, m_v, m_z, m_err;

  logic [N-1:0] alu_b;
  logic [N:0]   alu_sum;

  alu_sequencer #(.N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_op      (instr_op),
    .instr_operand (instr_operand),
    .instr_ready   (instr_ready),
    .alu_in0       (alu_in0),
    .alu_in1       (alu_in1),
    .alu_c_in      (alu_c_in),
    .alu_ctrl      (alu_ctrl),
    .alu_out       (alu_out),
    .alu_c_out     (alu_c_out),
    .alu_v         (alu_v),
    .acc           (acc),
    .flag_c        (flag_c),
    .flag_v        (flag_v),
    .flag_z        (flag_z),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Peer ALU: add/sub via adder with optional inverted B, logic ops report no carry/overflow.
  always_comb begin
    alu_b     = (alu_ctrl == 3'b001) ? ~alu_in1 : alu_in1;
    alu_sum   = {1'b0, alu_in0} + {1'b0, alu_b} + {{N{1'b0}}, alu_c_in};
    alu_out   = '0;
    alu_c_out = 1'b0;
    alu_v     = 1'b0;
    case (alu_ctrl)
      3'b000, 3'b001: begin
        alu_out   = alu_sum[N-1:0];
        alu_c_out = alu_sum[N];
        alu_v     = (alu_in0[N-1] == alu_b[N-1]) && (alu_sum[N-1] != alu_in0[N-1]);
      end
      3'b010:  alu_out = alu_in0 | alu_in1;
      3'b011:  alu_out = alu_in0 | ~alu_in1;
      3'b100:  alu_out = alu_in0 & alu_in1;
      3'b101:  alu_out = alu_in0 & ~alu_in1;
      3'b110:  alu_out = ~alu_in0;
      default: alu_out = ~alu_in1;
    endcase
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - MOD : x;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_exec(input int op, input int opnd);
    int r, sr, cin;
    cin = (op == 3 && m_c) ? 1 : 0;
    case (op)
      0: ;
      1: begin m_acc = opnd; m_z = (m_acc == 0); end
      2, 3: begin
        r   = m_acc + opnd + cin;
        sr  = to_signed(m_acc) + to_signed(opnd) + cin;
        m_c = (r >= MOD);
        m_v = (sr >= HALF) || (sr < -HALF);
        m_acc = r % MOD;
        m_z = (m_acc == 0);
      end
      4, 8: begin
        sr  = to_signed(m_acc) - to_signed(opnd);
        m_c = (m_acc >= opnd);
        m_v = (sr >= HALF) || (sr < -HALF);
        m_z = (m_acc == opnd);
        if (op == 4) m_acc = (m_acc - opnd + MOD) % MOD;
      end
      5: begin m_acc = m_acc | opnd; m_z = (m_acc == 0); end
      6: begin m_acc = m_acc & opnd; m_z = (m_acc == 0); end
      7: begin m_acc = MOD - 1 - m_acc; m_z = (m_acc == 0); end
      9: begin
        m_acc = (m_acc * opnd) % MOD;
        m_z = (m_acc == 0); m_c = 1'b0; m_v = 1'b0;
      end
      default: m_err = 1'b1;
    endcase
  endtask

  // Issues one instruction and reports cycles from accept to done, acc just before done,
  // and whether done was still high one cycle later.
  task automatic run_instr(input logic [3:0] op, input logic [N-1:0] opnd,
                           output int lat, output logic [N-1:0] acc_pre, output logic done_after);
    int guard;
    guard = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    instr_valid = 1'b1; instr_op = op; instr_operand = opnd;
    @(posedge clk);
    model_exec(int'(op), int'(opnd));
    @(negedge clk);
    instr_valid = 1'b0; instr_op = 4'($urandom); instr_operand = N'($urandom);
    lat = 1;
    acc_pre = acc;
    while (done !== 1'b1 && lat < 40) begin
      acc_pre = acc;
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = OP_NOP; instr_operand = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({acc, flag_c, flag_v, flag_z, err, done} !== {4'd0, 5'b00000}) begin
      errors++;
      $display("[TB] FAIL reset_state: got acc=%0d c=%b v=%b z=%b err=%b done=%b, expected all zero",
               acc, flag_c, flag_v, flag_z, err, done);
    end
    checks++;
    if (instr_ready !== 1'b1 || alu_ctrl !== 3'b000 || alu_in1 !== 4'd0 || alu_c_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b ctrl=%b in1=%0d cin=%b, expected 1 000 0 0",
               instr_ready, alu_ctrl, alu_in1, alu_c_in);
    end
    instr_valid = 1'b1; instr_op = OP_LDA; instr_operand = 4'd9;
    rst_n = 1'b1;
    @(posedge clk);
    model_exec(1, 9);
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_edge_accept: got ready=%b, expected 0", instr_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || acc !== 4'd9 || flag_z !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_lda: got done=%b acc=%0d z=%b, expected done=1 acc=9 z=0", done, acc, flag_z);
    end
  endtask

  task automatic test_directed();
    int lat;
    logic [N-1:0] pre;
    logic dn;
    run_instr(OP_LDA, 4'd7, lat, pre, dn);
    run_instr(OP_ADD, 4'd9, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_v, flag_z} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL add_wrap: got acc=%0d c=%b v=%b z=%b, expected acc=0 c=1 v=0 z=1", acc, flag_c, flag_v, flag_z);
    end
    checks++;
    if (lat != 2 || dn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_latency: got done after %0d cycles, late done=%b, expected 2 and 0", lat, dn);
    end
    run_instr(OP_LDA, 4'd7, lat, pre, dn);
    run_instr(OP_ADD, 4'd1, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_v} !== {4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL add_overflow: got acc=%0d c=%b v=%b, expected acc=8 c=0 v=1", acc, flag_c, flag_v);
    end
    run_instr(OP_ADD, 4'd15, lat, pre, dn);
    run_instr(OP_ADC, 4'd0, lat, pre, dn);
    checks++;
    if (acc !== 4'd8) begin
      errors++;
      $display("[TB] FAIL adc_carry_in: got acc=%0d, expected 8", acc);
    end
    run_instr(OP_LDA, 4'd5, lat, pre, dn);
    run_instr(OP_CMP, 4'd5, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_z} !== {4'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL cmp_equal: got acc=%0d c=%b z=%b, expected acc=5 c=1 z=1", acc, flag_c, flag_z);
    end
    run_instr(OP_OR, 4'd10, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_v, flag_z} !== {4'd15, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL or_keeps_cv: got acc=%0d c=%b v=%b z=%b, expected acc=15 c=1 v=0 z=0", acc, flag_c, flag_v, flag_z);
    end
    run_instr(OP_AND, 4'd0, lat, pre, dn);
    run_instr(OP_NOT, 4'd0, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_z} !== {4'd15, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL not_acc: got acc=%0d c=%b z=%b, expected acc=15 c=1 z=0", acc, flag_c, flag_z);
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [N-1:0] pre;
    logic dn;
    run_instr(OP_LDA, 4'd3, lat, pre, dn);
    run_instr(OP_MUL, 4'd5, lat, pre, dn);
    checks++;
    if (pre !== 4'd3) begin
      errors++;
      $display("[TB] FAIL mul_acc_early: got acc=%0d one cycle before retire, expected 3", pre);
    end
    checks++;
    if (acc !== 4'd15 || lat != N + 1 || dn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_timing: got acc=%0d done after %0d late=%b, expected acc=15 after %0d late=0", acc, lat, dn, N + 1);
    end
    run_instr(OP_LDA, 4'd1, lat, pre, dn);
    run_instr(OP_ADD, 4'd15, lat, pre, dn);
    run_instr(OP_LDA, 4'd6, lat, pre, dn);
    run_instr(OP_MUL, 4'd3, lat, pre, dn);
    checks++;
    if ({acc, flag_c, flag_v, flag_z} !== {4'd2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mul_wrap: got acc=%0d c=%b v=%b z=%b, expected acc=2 c=0 v=0 z=0", acc, flag_c, flag_v, flag_z);
    end
    run_instr(OP_LDA, 4'd4, lat, pre, dn);
    run_instr(OP_MUL, 4'd4, lat, pre, dn);
    checks++;
    if ({acc, flag_z} !== {4'd0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL mul_zero: got acc=%0d z=%b, expected acc=0 z=1", acc, flag_z);
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [N-1:0] pre;
    logic dn;
    run_instr(OP_LDA, 4'd10, lat, pre, dn);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got err=%b, expected 0", err);
    end
    run_instr(4'd12, 4'd3, lat, pre, dn);
    checks++;
    if (err !== 1'b1 || acc !== 4'd10 || {flag_c, flag_v, flag_z} !== {m_c, m_v, m_z}) begin
      errors++;
      $display("[TB] FAIL illegal_op: got err=%b acc=%0d cvz=%b%b%b, expected err=1 acc=10 cvz=%b%b%b",
               err, acc, flag_c, flag_v, flag_z, m_c, m_v, m_z);
    end
    checks++;
    if (lat != 2 || dn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_done: got done after %0d late=%b, expected 2 and 0", lat, dn);
    end
    run_instr(OP_NOP, 4'd6, lat, pre, dn);
    checks++;
    if (err !== 1'b1 || acc !== 4'd10 || lat != 2) begin
      errors++;
      $display("[TB] FAIL err_sticky_nop: got err=%b acc=%0d lat=%0d, expected err=1 acc=10 lat=2", err, acc, lat);
    end
  endtask

  task automatic test_hold_valid();
    int dones, readies, guard;
    dones = 0; readies = 0; guard = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    instr_valid = 1'b1; instr_op = OP_ADD; instr_operand = 4'd1;
    model_exec(2, 1);
    model_exec(2, 1);
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (instr_ready === 1'b1) begin
        readies++;
        instr_operand = 4'd1;
        checks++;
        if (alu_in1 !== 4'd0 || alu_ctrl !== 3'b000 || alu_in0 !== acc || alu_c_in !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_alu_drive: got in0=%0d in1=%0d ctrl=%b cin=%b, expected in0=acc=%0d in1=0 ctrl=000 cin=0",
                   alu_in0, alu_in1, alu_ctrl, alu_c_in, acc);
        end
      end else begin
        instr_operand = N'($urandom);
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (dones != 2 || readies != 2) begin
      errors++;
      $display("[TB] FAIL hold_valid_accepts: got %0d done pulses and %0d ready cycles, expected 2 and 2", dones, readies);
    end
    checks++;
    if (acc !== N'(m_acc) || {flag_c, flag_v, flag_z} !== {m_c, m_v, m_z}) begin
      errors++;
      $display("[TB] FAIL hold_valid_result: got acc=%0d cvz=%b%b%b, expected acc=%0d cvz=%b%b%b",
               acc, flag_c, flag_v, flag_z, m_acc, m_c, m_v, m_z);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat, dones;
    logic [N-1:0] pre;
    logic dn;
    run_instr(OP_LDA, 4'd3, lat, pre, dn);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = OP_MUL; instr_operand = 4'd5;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({acc, flag_c, flag_v, flag_z, err, done, instr_ready} !== {4'd0, 6'b000001}) begin
      errors++;
      $display("[TB] FAIL reset_mid_mul: got acc=%0d c=%b v=%b z=%b err=%b done=%b ready=%b, expected zeros and ready=1",
               acc, flag_c, flag_v, flag_z, err, done, instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done === 1'b1 || instr_ready !== 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || acc !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got %0d cycles with done or not-ready, acc=%0d, expected 0 and acc=0", dones, acc);
    end
  endtask

  task automatic test_random();
    int lat, op;
    logic [N-1:0] pre, opnd;
    logic dn;
    for (int i = 0; i < 80; i++) begin
      op   = int'($urandom_range(0, 11));
      opnd = N'($urandom);
      run_instr(4'(op), opnd, lat, pre, dn);
      checks++;
      if (acc !== N'(m_acc)) begin
        errors++;
        $display("[TB] FAIL rand_acc[%0d] op=%0d opnd=%0d: got acc=%0d, expected %0d", i, op, opnd, acc, m_acc);
      end
      checks++;
      if ({flag_c, flag_v, flag_z} !== {m_c, m_v, m_z}) begin
        errors++;
        $display("[TB] FAIL rand_flags[%0d] op=%0d opnd=%0d: got cvz=%b%b%b, expected %b%b%b",
                 i, op, opnd, flag_c, flag_v, flag_z, m_c, m_v, m_z);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("[TB] FAIL rand_err[%0d] op=%0d: got err=%b, expected %b", i, op, err, m_err);
      end
      checks++;
      if (lat != ((op == 9) ? N + 1 : 2) || dn !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_latency[%0d] op=%0d: got done after %0d late=%b, expected %0d and 0",
                 i, op, lat, dn, (op == 9) ? N + 1 : 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul();
    test_illegal();
    test_hold_valid();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
